synapse_current_gen: RTL

Upstream input stage for the tiny SNN. It converts a vector of binary input spikes into the unsigned 8-bit input current consumed by `spiking_neuron`. It holds one programmable weight per input synapse, loaded over a valid/ready stream. Each enabled cycle it integrates the weighted spike sum into a leaky, saturating current register whose output drives the neuron's `inn` port directly.

---
 rtl/snn_pkg.sv | 22 ++
 rtl/weighted_spike_adder.sv | 21 ++
 rtl/synapse_current_gen.sv | 128 ++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the tiny SNN: default widths, the leak shift,
// the weight-load FSM states and the current saturation limit.
package snn_pkg;

    localparam int N_IN_DEF        = 8;
    localparam int W_WIDTH_DEF     = 4;
    localparam int CUR_WIDTH_DEF   = 8;
    localparam int DECAY_SHIFT_DEF = 2;

    localparam int unsigned CUR_SAT_DEF = (1 << CUR_WIDTH_DEF) - 1;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } syn_state_e;

    // Largest current representable at a given width.
    function automatic int unsigned sat_limit(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/weighted_spike_adder.sv
// Combinational sum of the weights whose input spike is set.
module weighted_spike_adder #(
    parameter int N_IN    = 8,
    parameter int W_WIDTH = 4,
    parameter int SUM_W   = W_WIDTH + $clog2(N_IN)
) (
    input  logic [N_IN-1:0]         spike,
    input  logic [N_IN*W_WIDTH-1:0] weights,
    output logic [SUM_W-1:0]        sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (spike[i]) begin
                sum = sum + SUM_W'(weights[i*W_WIDTH +: W_WIDTH]);
            end
        end
    end

endmodule

// File: rtl/synapse_current_gen.sv
// Synapse input stage: streamed weight load, then a leaky saturating
// integrator of the weighted spike sum that feeds the neuron current input.
module synapse_current_gen
    import snn_pkg::*;
#(
    parameter int N_IN        = N_IN_DEF,
    parameter int W_WIDTH     = W_WIDTH_DEF,
    parameter int CUR_WIDTH   = CUR_WIDTH_DEF,
    parameter int DECAY_SHIFT = DECAY_SHIFT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N_IN-1:0]      spike_in,
    input  logic                 wload_start,
    input  logic                 wload_valid,
    input  logic [W_WIDTH-1:0]   wload_data,
    output logic                 wload_ready,
    output logic                 weights_ready,
    output logic [CUR_WIDTH-1:0] current_out
);

    localparam int PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int SUM_W = W_WIDTH + $clog2(N_IN);
    localparam int ACC_W = CUR_WIDTH + 2;
    localparam logic [ACC_W-1:0] SAT = ACC_W'(sat_limit(CUR_WIDTH));

    syn_state_e           state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [W_WIDTH-1:0]   weight_q [N_IN];
    logic [W_WIDTH-1:0]   weight_d [N_IN];
    logic [CUR_WIDTH-1:0] current_q, current_d;
    logic                 wload_ready_q, wload_ready_d;
    logic                 weights_ready_q, weights_ready_d;

    logic [N_IN*W_WIDTH-1:0] weights_flat;
    logic [SUM_W-1:0]        syn_sum;
    logic [ACC_W-1:0]        cur_ext, leak, next_acc;

    always_comb begin
        weights_flat = '0;
        for (int i = 0; i < N_IN; i++) begin
            weights_flat[i*W_WIDTH +: W_WIDTH] = weight_q[i];
        end
    end

    weighted_spike_adder #(
        .N_IN    (N_IN),
        .W_WIDTH (W_WIDTH),
        .SUM_W   (SUM_W)
    ) u_adder (
        .spike   (spike_in),
        .weights (weights_flat),
        .sum     (syn_sum)
    );

    // Leak never exceeds the current, so the subtraction cannot underflow;
    // a minimum leak of 1 lets small currents decay all the way to zero.
    always_comb begin
        cur_ext = ACC_W'(current_q);
        leak    = cur_ext >> DECAY_SHIFT;
        if (cur_ext != '0 && leak == '0) begin
            leak = ACC_W'(1);
        end
        next_acc = cur_ext - leak + ACC_W'(syn_sum);
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        weight_d  = weight_q;
        current_d = current_q;

        // A start overrides the handshake: a beat presented with it is
        // taken as weight 0 even while in RUN.
        if (wload_start) begin
            state_d   = ST_LOAD;
            ptr_d     = '0;
            current_d = '0;
            if (wload_valid) begin
                weight_d[0] = wload_data;
                ptr_d       = PTR_W'(1);
            end
        end else if (state_q == ST_LOAD) begin
            if (wload_valid && wload_ready_q) begin
                weight_d[ptr_q] = wload_data;
                if (ptr_q == PTR_W'(N_IN - 1)) begin
                    ptr_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
        end else if (en) begin
            current_d = (next_acc > SAT) ? CUR_WIDTH'(SAT) : CUR_WIDTH'(next_acc);
        end

        wload_ready_d   = (state_d == ST_LOAD);
        weights_ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_LOAD;
            ptr_q           <= '0;
            current_q       <= '0;
            wload_ready_q   <= 1'b1;
            weights_ready_q <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                weight_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            current_q       <= current_d;
            wload_ready_q   <= wload_ready_d;
            weights_ready_q <= weights_ready_d;
            for (int i = 0; i < N_IN; i++) begin
                weight_q[i] <= weight_d[i];
            end
        end
    end

    assign wload_ready   = wload_ready_q;
    assign weights_ready = weights_ready_q;
    assign current_out   = current_q;

endmodule
